// File: rtl/datapath_mc.sv
// Multi-cycle register-file + ALU datapath with a req/ack memory port.
// One instruction per start handshake: IDLE -> EXEC -> (MEM) -> WB.
module datapath_mc #(
  parameter int NBITS      = 8,
  parameter int NREGS      = 32,
  parameter int WIDTH_ALUF = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic [$clog2(NREGS)-1:0] RS1,
  input  logic [$clog2(NREGS)-1:0] RS2,
  input  logic [$clog2(NREGS)-1:0] RD,
  input  logic signed [NBITS-1:0]  IMM,
  input  logic [WIDTH_ALUF-1:0]    ALUControl,
  input  logic                     ALUSrc,
  input  logic                     MemtoReg,
  input  logic                     MemWrite,
  input  logic                     RegWrite,
  input  logic                     link,
  input  logic [NBITS-1:0]         pclink,
  output logic                     Zero,
  output logic                     Neg,
  output logic                     Carry,
  output logic [NBITS-1:0]         PCReg,
  output logic [NBITS-1:0]         Address,
  output logic [NBITS-1:0]         WriteData,
  input  logic [NBITS-1:0]         ReadData,
  output logic                     MemReq,
  output logic                     MemWe,
  input  logic                     MemAck
);

  localparam int RW = $clog2(NREGS);
  localparam int SW = $clog2(NBITS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MEM  = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [WIDTH_ALUF-1:0] OP_SUB  = WIDTH_ALUF'(4'b1000);
  localparam logic [WIDTH_ALUF-1:0] OP_SLL  = WIDTH_ALUF'(4'b0001);
  localparam logic [WIDTH_ALUF-1:0] OP_SLT  = WIDTH_ALUF'(4'b0010);
  localparam logic [WIDTH_ALUF-1:0] OP_SLTU = WIDTH_ALUF'(4'b0011);
  localparam logic [WIDTH_ALUF-1:0] OP_XOR  = WIDTH_ALUF'(4'b0100);
  localparam logic [WIDTH_ALUF-1:0] OP_SRL  = WIDTH_ALUF'(4'b0101);
  localparam logic [WIDTH_ALUF-1:0] OP_SRA  = WIDTH_ALUF'(4'b1101);
  localparam logic [WIDTH_ALUF-1:0] OP_OR   = WIDTH_ALUF'(4'b0110);
  localparam logic [WIDTH_ALUF-1:0] OP_AND  = WIDTH_ALUF'(4'b0111);

  logic [1:0]            state;
  logic [NBITS-1:0]      rf [NREGS];
  logic [NBITS-1:0]      srca;
  logic [NBITS-1:0]      srcb;
  logic [NBITS-1:0]      pcl_q;
  logic [NBITS-1:0]      rdata_q;
  logic [WIDTH_ALUF-1:0] ctl_q;
  logic [RW-1:0]         rd_q;
  logic                  m2r_q;
  logic                  mw_q;
  logic                  rw_q;
  logic                  lnk_q;
  logic                  is_load;

  logic [NBITS-1:0]      alu_y;
  logic                  alu_c;
  logic [NBITS:0]        sum;
  logic [SW-1:0]         shamt;
  logic                  ge_u;
  logic [NBITS-1:0]      wb_val;

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_WB);
  assign MemReq  = (state == S_MEM);
  assign MemWe   = MemReq & mw_q;
  // A store that is also flagged as a load never writes memory data back.
  assign is_load = m2r_q & ~mw_q;
  assign wb_val  = lnk_q ? pcl_q : (is_load ? rdata_q : Address);

  always_comb begin
    shamt = srcb[SW-1:0];
    sum   = {1'b0, srca} + {1'b0, srcb};
    ge_u  = (srca >= srcb);
    alu_y = sum[NBITS-1:0];
    alu_c = sum[NBITS];
    case (ctl_q)
      OP_SUB: begin
        alu_y = srca - srcb;
        alu_c = ge_u;
      end
      OP_SLL: begin
        alu_y = srca << shamt;
        alu_c = 1'b0;
      end
      OP_SLT: begin
        alu_y = {{(NBITS-1){1'b0}},
                 ($signed(srca) < $signed(srcb))};
        alu_c = ge_u;
      end
      OP_SLTU: begin
        alu_y = {{(NBITS-1){1'b0}}, ~ge_u};
        alu_c = ge_u;
      end
      OP_XOR: begin
        alu_y = srca ^ srcb;
        alu_c = 1'b0;
      end
      OP_SRL: begin
        alu_y = srca >> shamt;
        alu_c = 1'b0;
      end
      OP_SRA: begin
        alu_y = $unsigned($signed(srca) >>> shamt);
        alu_c = 1'b0;
      end
      OP_OR: begin
        alu_y = srca | srcb;
        alu_c = 1'b0;
      end
      OP_AND: begin
        alu_y = srca & srcb;
        alu_c = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      srca      <= '0;
      srcb      <= '0;
      pcl_q     <= '0;
      rdata_q   <= '0;
      ctl_q     <= '0;
      rd_q      <= '0;
      m2r_q     <= 1'b0;
      mw_q      <= 1'b0;
      rw_q      <= 1'b0;
      lnk_q     <= 1'b0;
      Zero      <= 1'b0;
      Neg       <= 1'b0;
      Carry     <= 1'b0;
      PCReg     <= '0;
      Address   <= '0;
      WriteData <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            srca      <= rf[RS1];
            srcb      <= ALUSrc ? IMM : rf[RS2];
            WriteData <= rf[RS2];
            PCReg     <= rf[RS1];
            pcl_q     <= pclink;
            ctl_q     <= ALUControl;
            rd_q      <= RD;
            m2r_q     <= MemtoReg;
            mw_q      <= MemWrite;
            rw_q      <= RegWrite;
            lnk_q     <= link;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          Address <= alu_y;
          Zero    <= (alu_y == '0);
          Neg     <= alu_y[NBITS-1];
          Carry   <= alu_c;
          state   <= (m2r_q | mw_q) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (MemAck) begin
            if (is_load) rdata_q <= ReadData;
            state <= S_WB;
          end
        end
        S_WB: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (done && rw_q && (rd_q != '0)) begin
      rf[rd_q] <= wb_val;
    end
  end

endmodule

// File: tb/tb_datapath_mc.sv
// Directed scoreboard bench for datapath_mc.
// A monitor pops one expected result per done pulse.
module tb_datapath_mc;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic [4:0]        RS1 = '0;
  logic [4:0]        RS2 = '0;
  logic [4:0]        RD = '0;
  logic signed [7:0] IMM = '0;
  logic [3:0]        ALUControl = '0;
  logic              ALUSrc = 1'b0;
  logic              MemtoReg = 1'b0;
  logic              MemWrite = 1'b0;
  logic              RegWrite = 1'b0;
  logic              link = 1'b0;
  logic [7:0]        pclink = '0;
  logic              Zero;
  logic              Neg;
  logic              Carry;
  logic [7:0]        PCReg;
  logic [7:0]        Address;
  logic [7:0]        WriteData;
  logic [7:0]        ReadData = '0;
  logic              MemReq;
  logic              MemWe;
  logic              MemAck = 1'b0;

  datapath_mc #(.NBITS(8), .NREGS(32), .WIDTH_ALUF(4)) dut (
    .clock(clock), .reset(reset), .start(start),
    .busy(busy), .done(done),
    .RS1(RS1), .RS2(RS2), .RD(RD), .IMM(IMM),
    .ALUControl(ALUControl), .ALUSrc(ALUSrc),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .link(link), .pclink(pclink),
    .Zero(Zero), .Neg(Neg), .Carry(Carry),
    .PCReg(PCReg), .Address(Address),
    .WriteData(WriteData), .ReadData(ReadData),
    .MemReq(MemReq), .MemWe(MemWe), .MemAck(MemAck)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [7:0] pc;
    logic [7:0] addr;
    logic [7:0] wd;
    logic [2:0] flg;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  logic [7:0] mem [256] = '{default: 8'hAA};
  int         ack_delay = 0;
  int         cnt = 0;
  int         last_req = 0;
  logic [7:0] addr0 = '0;
  logic       moved = 1'b0;
  logic       we_last = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory model: acks after ack_delay extra MEM cycles.
  always @(negedge clock) begin
    if (MemReq) begin
      if (cnt == 0) begin
        addr0 <= Address;
        moved <= 1'b0;
      end else if (Address !== addr0) begin
        moved <= 1'b1;
      end
      we_last <= MemWe;
      MemAck  <= (cnt == ack_delay);
      if (cnt == ack_delay) begin
        ReadData <= mem[Address];
        if (MemWe) mem[Address] <= WriteData;
      end
      cnt <= cnt + 1;
    end else begin
      MemAck <= 1'b0;
      if (cnt != 0) last_req <= cnt;
      cnt <= 0;
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (reset && done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no op");
      end else begin
        e = q.pop_front();
        chk({e.name, ".PCReg"}, PCReg, e.pc);
        chk({e.name, ".Address"}, Address, e.addr);
        chk({e.name, ".WriteData"}, WriteData, e.wd);
        chk({e.name, ".ZNC"}, {Zero, Neg, Carry}, e.flg);
      end
    end
  end

  task automatic issue(
    string nm, logic [3:0] ctl, int rs1, int rs2, int rd,
    logic [7:0] imm, bit src, bit m2r, bit mw, bit rw,
    bit lnk, logic [7:0] pcl, logic [7:0] epc,
    logic [7:0] eaddr, logic [7:0] ewd, logic [2:0] eflg,
    int lat, bit junk = 1'b0);
    exp_t e;
    int   n;
    bit   seen;
    e.name = nm;
    e.pc   = epc;
    e.addr = eaddr;
    e.wd   = ewd;
    e.flg  = eflg;
    q.push_back(e);
    ALUControl = ctl;
    RS1 = 5'(rs1);
    RS2 = 5'(rs2);
    RD = 5'(rd);
    IMM = imm;
    ALUSrc = src;
    MemtoReg = m2r;
    MemWrite = mw;
    RegWrite = rw;
    link = lnk;
    pclink = pcl;
    start = 1'b1;
    n = 0;
    seen = 1'b0;
    while (n < 200) begin
      @(negedge clock);
      n++;
      start = junk;
      if (done && !seen) begin
        chk({nm, ".latency"}, n, lat);
        seen = 1'b1;
      end
      if (!busy) break;
    end
    start = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: got no done expected done", nm);
    end
    if (m2r || mw) begin
      chk({nm, ".req_cycles"}, last_req, ack_delay + 1);
      chk({nm, ".addr_stable"}, moved, 0);
      chk({nm, ".MemWe"}, we_last, mw);
    end
  endtask

  task automatic rd_reg(string nm, int r, logic [7:0] v);
    issue(nm, 4'h0, r, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00,
          v, v, 8'h00, {v == 8'h00, v[7], 1'b0}, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(negedge clock);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.MemReq", MemReq, 0);
    chk("rst.MemWe", MemWe, 0);
    chk("rst.ZNC", {Zero, Neg, Carry}, 3'b000);
    chk("rst.PCReg", PCReg, 0);
    chk("rst.Address", Address, 0);
    chk("rst.WriteData", WriteData, 0);
    reset = 1'b1;
    @(negedge clock);

    issue("add_x1", 4'h0, 0, 0, 1, 8'h05, 1, 0, 0, 1, 0, 0,
          8'h00, 8'h05, 8'h00, 3'b000, 2);
    issue("sub_x2", 4'h8, 1, 0, 2, 8'h07, 1, 0, 0, 1, 0, 0,
          8'h05, 8'hFE, 8'h00, 3'b010, 2);
    issue("sub_x3", 4'h8, 1, 1, 3, 8'h00, 0, 0, 0, 1, 0, 0,
          8'h05, 8'h00, 8'h05, 3'b101, 2);
    issue("wr_x0", 4'h0, 0, 0, 0, 8'h55, 1, 0, 0, 1, 0, 0,
          8'h00, 8'h55, 8'h00, 3'b000, 2);
    rd_reg("rd_x0", 0, 8'h00);
    issue("link_x5", 4'h0, 1, 0, 5, 8'h01, 1, 0, 0, 1, 1, 8'h3C,
          8'h05, 8'h06, 8'h00, 3'b000, 2);
    rd_reg("rd_x5", 5, 8'h3C);
    rd_reg("rd_x2", 2, 8'hFE);
    rd_reg("rd_x3", 3, 8'h00);

    ack_delay = 3;
    issue("store", 4'h0, 0, 1, 0, 8'h10, 1, 0, 1, 0, 0, 0,
          8'h00, 8'h10, 8'h05, 3'b000, 6);
    issue("load_x6", 4'h0, 0, 0, 6, 8'h10, 1, 1, 0, 1, 0, 0,
          8'h00, 8'h10, 8'h00, 3'b000, 6);
    rd_reg("rd_x6", 6, 8'h05);
    ack_delay = 0;
    issue("st_ld_x12", 4'h0, 0, 6, 12, 8'h20, 1, 1, 1, 1, 0, 0,
          8'h00, 8'h20, 8'h05, 3'b000, 3);
    rd_reg("rd_x12", 12, 8'h20);
    chk("mem20", mem[8'h20], 8'h05);

    issue("add_x7", 4'h0, 0, 0, 7, 8'h80, 1, 0, 0, 1, 0, 0,
          8'h00, 8'h80, 8'h00, 3'b010, 2);
    issue("sra", 4'hD, 7, 0, 0, 8'h03, 1, 0, 0, 0, 0, 0,
          8'h80, 8'hF0, 8'h00, 3'b010, 2);
    issue("srl", 4'h5, 7, 0, 0, 8'h03, 1, 0, 0, 0, 0, 0,
          8'h80, 8'h10, 8'h00, 3'b000, 2);
    issue("sll", 4'h1, 7, 0, 0, 8'h03, 1, 0, 0, 0, 0, 0,
          8'h80, 8'h00, 8'h00, 3'b100, 2);
    issue("add_x8", 4'h0, 0, 0, 8, 8'hFF, 1, 0, 0, 1, 0, 0,
          8'h00, 8'hFF, 8'h00, 3'b010, 2);
    issue("slt", 4'h2, 8, 0, 0, 8'h01, 1, 0, 0, 0, 0, 0,
          8'hFF, 8'h01, 8'h00, 3'b001, 2);
    issue("sltu", 4'h3, 8, 0, 0, 8'h01, 1, 0, 0, 0, 0, 0,
          8'hFF, 8'h00, 8'h00, 3'b101, 2);
    issue("add_wrap", 4'h0, 8, 0, 0, 8'h01, 1, 0, 0, 0, 0, 0,
          8'hFF, 8'h00, 8'h00, 3'b101, 2);
    issue("sub_nb", 4'h8, 8, 0, 0, 8'h01, 1, 0, 0, 0, 0, 0,
          8'hFF, 8'hFE, 8'h00, 3'b011, 2);
    issue("xor", 4'h4, 7, 0, 0, 8'hFF, 1, 0, 0, 0, 0, 0,
          8'h80, 8'h7F, 8'h00, 3'b000, 2);
    issue("and", 4'h7, 8, 0, 0, 8'h0F, 1, 0, 0, 0, 0, 0,
          8'hFF, 8'h0F, 8'h00, 3'b000, 2);
    issue("or", 4'h6, 7, 0, 0, 8'h01, 1, 0, 0, 0, 0, 0,
          8'h80, 8'h81, 8'h00, 3'b010, 2);
    issue("dflt_add", 4'hF, 1, 0, 0, 8'h03, 1, 0, 0, 0, 0, 0,
          8'h05, 8'h08, 8'h00, 3'b000, 2);

    issue("junk_exec", 4'h0, 1, 0, 9, 8'h01, 1, 0, 0, 1, 0, 0,
          8'h05, 8'h06, 8'h00, 3'b000, 2, 1'b1);
    ack_delay = 2;
    issue("junk_mem", 4'h0, 0, 0, 10, 8'h10, 1, 1, 0, 1, 0, 0,
          8'h00, 8'h10, 8'h00, 3'b000, 5, 1'b1);
    repeat (3) @(negedge clock);
    chk("junk.idle", busy, 0);
    rd_reg("rd_x9", 9, 8'h06);
    rd_reg("rd_x10", 10, 8'h05);

    ack_delay = 100;
    ALUControl = 4'h0;
    RS1 = 5'd0;
    IMM = 8'h30;
    ALUSrc = 1'b1;
    MemtoReg = 1'b1;
    MemWrite = 1'b0;
    RegWrite = 1'b1;
    RD = 5'd11;
    link = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    k = 0;
    while (!MemReq && k < 10) begin
      @(negedge clock);
      k++;
    end
    chk("rstmem.MemReq_seen", MemReq, 1);
    #2 reset = 1'b0;
    #1;
    chk("rstmem.MemReq", MemReq, 0);
    chk("rstmem.busy", busy, 0);
    chk("rstmem.done", done, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rstmem.idle", busy, 0);
    chk("rstmem.ZNC", {Zero, Neg, Carry}, 3'b000);
    chk("rstmem.Address", Address, 0);
    ack_delay = 0;
    for (int r = 1; r < 32; r++)
      rd_reg($sformatf("rst_x%0d", r), r, 8'h00);
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
